dmem_responder: RTL

Responder end of the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, performs it against byte-addressed little-endian storage after a fixed, parameterised latency, and returns a registered response. It replaces the zero-latency data memory on the load/store path of the pipelined core. The core stalls its memory stage on `req_ready`/`rsp_valid`.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, the RV32I load/store funct3 codes and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed storage built from four byte lanes.
// Writes are synchronous with per-lane byte enables; the word read is combinational.
module dmem_array #(
  parameter int WORD_AW = 15
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_mem [2**WORD_AW];

    always_ff @(posedge clk) begin
      if (we && be[i]) lane_mem[addr] <= wdata[8*i +: 8];
    end

    assign rdata[8*i +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory port: one request at a time, fixed latency,
// registered response. Stores commit and loads sample on the edge that enters RESP.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready=1, waiting for req_valid; request latched on accept
// WAIT    | latency down-counter running; terminal count performs access
// RESP    | rsp_valid=1, outputs held until rsp_ready
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  import dmem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_write;
  logic [2:0]            lat_funct3;
  logic [31:0]           lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  f3_ok, misaligned, out_of_range, req_err;
  logic                  commit, mem_we;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_word, rd_shift, load_data;

  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      lat_write  <= req_write;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // Stores only accept the three signed size codes; loads also allow BU/HU.
  always_comb begin
    f3_ok = 1'b0;
    case (lat_funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !lat_write;
      default:          f3_ok = 1'b0;
    endcase
    misaligned   = ((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                   ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
    out_of_range = (lat_addr >> ADDRESS_WIDTH) != 32'd0;
  end

  assign req_err = !f3_ok || misaligned || out_of_range;
  assign commit  = (state == ST_WAIT) && (cnt == '0);
  assign mem_we  = commit && lat_write && !req_err && !rst;

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = lat_wdata;
    case (lat_funct3[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << lat_addr[1:0];
        mem_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = lat_wdata;
      end
    endcase
  end

  dmem_array #(.WORD_AW(ADDRESS_WIDTH - 2)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (lat_addr[ADDRESS_WIDTH-1:2]),
    .wdata (mem_wdata),
    .rdata (rd_word)
  );

  assign rd_shift = rd_word >> {lat_addr[1:0], 3'b000};

  always_comb begin
    load_data = '0;
    case (lat_funct3)
      F3_B:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_H:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_W:    load_data = rd_shift;
      F3_BU:   load_data = {24'd0, rd_shift[7:0]};
      F3_HU:   load_data = {16'd0, rd_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || lat_write) ? '0 : load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
